// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the writeback register file and its producer stage.
package wb_regfile_pkg;

    localparam int unsigned REG_NUM_DEFAULT = 32;
    localparam logic [31:0] ZERO_WORD       = '0;
    localparam logic [63:0] ZERO_DWORD      = '0;

    typedef logic [4:0] RegAddr_t;

    typedef struct packed {
        logic        we;
        RegAddr_t    waddr;
        logic [31:0] wdata;
    } RegWriteReq_t;

    typedef struct packed {
        logic        we;
        logic [63:0] hilo;
    } HiloWriteReq_t;

    // A GPR write only counts as an architectural commit when it targets a real register.
    function automatic logic is_commit(RegWriteReq_t req);
        return req.we && (req.waddr != '0);
    endfunction

endpackage

// File: rtl/wb_regfile_trace.sv
// Registered commit trace: last committed GPR index/value plus a running commit count.
module regfile_trace
    import wb_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        commit_i,
    input  RegAddr_t    waddr_i,
    input  logic [31:0] wdata_i,
    output logic        valid_o,
    output RegAddr_t    waddr_o,
    output logic [31:0] wdata_o,
    output logic [31:0] count_o
);

    logic        valid_q, valid_d;
    RegAddr_t    waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] count_q, count_d;

    always_comb begin
        valid_d = commit_i;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        if (commit_i) begin
            waddr_d = waddr_i;
            wdata_d = wdata_i;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= ZERO_WORD;
            count_q <= ZERO_WORD;
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
        end
    end

    assign valid_o = valid_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign count_o = count_q;

endmodule

// File: rtl/wb_regfile.sv
// Architectural GPR file (r0 = 0) plus HI/LO, with same-cycle write bypass and commit trace.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned REG_NUM  = REG_NUM_DEFAULT,
    parameter bit          TRACE_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  RegWriteReq_t  wb_reg_wr,
    input  HiloWriteReq_t wb_hilo_wr,
    input  RegAddr_t      raddr1,
    input  RegAddr_t      raddr2,
    output logic [31:0]   rdata1,
    output logic [31:0]   rdata2,
    output logic [63:0]   hilo_rdata,
    output logic          trace_valid,
    output RegAddr_t      trace_waddr,
    output logic [31:0]   trace_wdata,
    output logic [31:0]   trace_count
);

    logic [31:0] gpr_q [REG_NUM];
    logic [63:0] hilo_q, hilo_d;
    logic        gpr_we;

    assign gpr_we = is_commit(wb_reg_wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                gpr_q[i] <= ZERO_WORD;
            end
        end else if (gpr_we) begin
            gpr_q[wb_reg_wr.waddr] <= wb_reg_wr.wdata;
        end
    end

    assign hilo_d = wb_hilo_wr.we ? wb_hilo_wr.hilo : hilo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hilo_q <= ZERO_DWORD;
        end else begin
            hilo_q <= hilo_d;
        end
    end

    // gpr_we already excludes r0, so it doubles as the bypass qualifier for nonzero read addresses.
    always_comb begin
        rdata1 = ZERO_WORD;
        if (raddr1 != '0) begin
            rdata1 = (gpr_we && (wb_reg_wr.waddr == raddr1)) ? wb_reg_wr.wdata : gpr_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = ZERO_WORD;
        if (raddr2 != '0) begin
            rdata2 = (gpr_we && (wb_reg_wr.waddr == raddr2)) ? wb_reg_wr.wdata : gpr_q[raddr2];
        end
    end

    assign hilo_rdata = hilo_d;

    generate
        if (TRACE_EN) begin : gen_trace
            regfile_trace u_trace (
                .clk      (clk),
                .rst_n    (rst_n),
                .commit_i (gpr_we),
                .waddr_i  (wb_reg_wr.waddr),
                .wdata_i  (wb_reg_wr.wdata),
                .valid_o  (trace_valid),
                .waddr_o  (trace_waddr),
                .wdata_o  (trace_wdata),
                .count_o  (trace_count)
            );
        end else begin : gen_no_trace
            assign trace_valid = 1'b0;
            assign trace_waddr = '0;
            assign trace_wdata = ZERO_WORD;
            assign trace_count = ZERO_WORD;
        end
    endgenerate

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: behavioural model compared every cycle plus literal expectations.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    RegWriteReq_t  wb_reg_wr;
    HiloWriteReq_t wb_hilo_wr;
    RegAddr_t      raddr1, raddr2;
    logic [31:0]   rdata1, rdata2;
    logic [63:0]   hilo_rdata;
    logic          trace_valid;
    RegAddr_t      trace_waddr;
    logic [31:0]   trace_wdata, trace_count;

    wb_regfile #(.REG_NUM(32), .TRACE_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_reg_wr   (wb_reg_wr),
        .wb_hilo_wr  (wb_hilo_wr),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .hilo_rdata  (hilo_rdata),
        .trace_valid (trace_valid),
        .trace_waddr (trace_waddr),
        .trace_wdata (trace_wdata),
        .trace_count (trace_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: register contents, HI/LO and the trace as the rules describe them.
    logic [31:0] m_gpr [32];
    logic [63:0] m_hilo;
    logic        m_tv;
    logic [4:0]  m_ta;
    logic [31:0] m_td;
    logic [31:0] m_cnt;
    logic        preset = 1'b0;

    always @(posedge clk or negedge rst_n or posedge preset) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_gpr[i] <= 32'h0;
            m_hilo <= 64'h0;
            m_tv   <= 1'b0;
            m_ta   <= 5'd0;
            m_td   <= 32'h0;
            m_cnt  <= 32'h0;
        end else if (preset) begin
            m_cnt <= 32'hFFFF_FFFE;
        end else begin
            if (wb_reg_wr.we && wb_reg_wr.waddr != 5'd0) begin
                m_gpr[wb_reg_wr.waddr] <= wb_reg_wr.wdata;
                m_ta  <= wb_reg_wr.waddr;
                m_td  <= wb_reg_wr.wdata;
                m_cnt <= m_cnt + 32'd1;
                m_tv  <= 1'b1;
            end else begin
                m_tv  <= 1'b0;
            end
            if (wb_hilo_wr.we) m_hilo <= wb_hilo_wr.hilo;
        end
    end

    function automatic logic [31:0] exp_rd(input RegAddr_t a);
        if (a == 5'd0) return 32'h0;
        if (wb_reg_wr.we && wb_reg_wr.waddr == a) return wb_reg_wr.wdata;
        return m_gpr[a];
    endfunction

    always @(negedge clk) begin
        chk("cyc_rdata1", {32'h0, rdata1}, {32'h0, exp_rd(raddr1)});
        chk("cyc_rdata2", {32'h0, rdata2}, {32'h0, exp_rd(raddr2)});
        chk("cyc_hilo", hilo_rdata, wb_hilo_wr.we ? wb_hilo_wr.hilo : m_hilo);
        chk("cyc_tvalid", {63'h0, trace_valid}, {63'h0, m_tv});
        chk("cyc_twaddr", {59'h0, trace_waddr}, {59'h0, m_ta});
        chk("cyc_twdata", {32'h0, trace_wdata}, {32'h0, m_td});
        chk("cyc_tcount", {32'h0, trace_count}, {32'h0, m_cnt});
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            assert (!$isunknown({wb_reg_wr.we, wb_hilo_wr.we}))
                else $error("FAIL x_we: write enable unknown at %0t", $time);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_reg_wr.we    = we;
        wb_reg_wr.waddr = a;
        wb_reg_wr.wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        wb_reg_wr  = '0;
        wb_hilo_wr = '0;
        raddr1     = 5'd0;
        raddr2     = 5'd0;
        #2;
        chk("reset_rdata1", {32'h0, rdata1}, 64'h0);
        chk("reset_count", {32'h0, trace_count}, 64'h0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // write then read
        set_wr(1'b1, 5'd3, 32'hDEAD_BEEF);
        cyc();
        set_wr(1'b0, 5'd0, 32'h0);
        raddr1 = 5'd3;
        #1;
        chk("wr_rd_r3", {32'h0, rdata1}, 64'hDEAD_BEEF);
        chk("wr_tvalid", {63'h0, trace_valid}, 64'h1);
        chk("wr_twaddr", {59'h0, trace_waddr}, 64'd3);
        chk("wr_tcount", {32'h0, trace_count}, 64'd1);

        // r0 protection
        set_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        #1;
        chk("r0_same_p1", {32'h0, rdata1}, 64'h0);
        chk("r0_same_p2", {32'h0, rdata2}, 64'h0);
        cyc();
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        chk("r0_after_p1", {32'h0, rdata1}, 64'h0);
        chk("r0_tvalid", {63'h0, trace_valid}, 64'h0);
        chk("r0_tcount", {32'h0, trace_count}, 64'd1);

        // bypass on port 1, stored value on port 2
        set_wr(1'b1, 5'd7, 32'h11);
        cyc();
        set_wr(1'b1, 5'd8, 32'h88);
        cyc();
        set_wr(1'b1, 5'd7, 32'h22);
        raddr1 = 5'd7;
        raddr2 = 5'd8;
        #1;
        chk("byp_p1", {32'h0, rdata1}, 64'h22);
        chk("byp_p2_stored", {32'h0, rdata2}, 64'h88);
        cyc();
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        chk("byp_after", {32'h0, rdata1}, 64'h22);
        chk("byp_twdata", {32'h0, trace_wdata}, 64'h22);
        chk("byp_tcount", {32'h0, trace_count}, 64'd4);

        // both ports on the written register
        set_wr(1'b1, 5'd9, 32'h99);
        raddr1 = 5'd9;
        raddr2 = 5'd9;
        #1;
        chk("byp_both_p1", {32'h0, rdata1}, 64'h99);
        chk("byp_both_p2", {32'h0, rdata2}, 64'h99);
        cyc();
        // bypass on port 2 only
        set_wr(1'b1, 5'd7, 32'h77);
        raddr1 = 5'd3;
        raddr2 = 5'd7;
        #1;
        chk("byp2_p1", {32'h0, rdata1}, 64'hDEAD_BEEF);
        chk("byp2_p2", {32'h0, rdata2}, 64'h77);
        cyc();
        set_wr(1'b0, 5'd0, 32'h0);

        // HI/LO
        wb_hilo_wr = '{we: 1'b1, hilo: 64'h0000_0001_0000_0002};
        #1;
        chk("hilo_bypass", hilo_rdata, 64'h0000_0001_0000_0002);
        cyc();
        wb_hilo_wr = '{we: 1'b0, hilo: 64'hFFFF_FFFF_FFFF_FFFF};
        #1;
        chk("hilo_held", hilo_rdata, 64'h0000_0001_0000_0002);
        chk("hilo_tcount", {32'h0, trace_count}, 64'd6);
        chk("hilo_tvalid", {63'h0, trace_valid}, 64'h0);

        // asynchronous reset mid-run
        set_wr(1'b1, 5'd5, 32'h1234);
        cyc();
        set_wr(1'b0, 5'd0, 32'h0);
        raddr1 = 5'd5;
        raddr2 = 5'd6;
        #1;
        chk("pre_rst_r5", {32'h0, rdata1}, 64'h1234);
        rst_n = 1'b0;
        #1;
        chk("rst_r5", {32'h0, rdata1}, 64'h0);
        chk("rst_tcount", {32'h0, trace_count}, 64'h0);
        chk("rst_tvalid", {63'h0, trace_valid}, 64'h0);
        chk("rst_hilo", hilo_rdata, 64'h0);
        set_wr(1'b1, 5'd6, 32'h66);
        cyc();
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        chk("rst_no_write", {32'h0, rdata2}, 64'h0);
        set_wr(1'b1, 5'd6, 32'h66);
        #1;
        rst_n = 1'b1;
        cyc();
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        chk("post_rst_write", {32'h0, rdata2}, 64'h66);
        chk("post_rst_tcount", {32'h0, trace_count}, 64'd1);

        // counter wrap with a held write
        force dut.gen_trace.u_trace.count_q = 32'hFFFF_FFFE;
        preset = 1'b1;
        #1;
        release dut.gen_trace.u_trace.count_q;
        preset = 1'b0;
        set_wr(1'b1, 5'd4, 32'hAB);
        cyc();
        chk("wrap_c0", {32'h0, trace_count}, 64'hFFFF_FFFF);
        chk("wrap_v0", {63'h0, trace_valid}, 64'h1);
        cyc();
        chk("wrap_c1", {32'h0, trace_count}, 64'h0);
        chk("wrap_v1", {63'h0, trace_valid}, 64'h1);
        cyc();
        chk("wrap_c2", {32'h0, trace_count}, 64'h1);
        chk("wrap_v2", {63'h0, trace_valid}, 64'h1);
        set_wr(1'b0, 5'd0, 32'h0);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
